// File: rtl/nxn_board_game.sv
`default_nettype none
// ============================================================================
// Module      : nxn_board_game
// Description : N x N X/O board-game controller. Alternates player and
//               computer moves, rejects occupied or out-of-range cells with a
//               one-cycle illegal pulse, detects row/column/diagonal wins and
//               draws, and freezes until restart or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module nxn_board_game #(
  parameter  int N     = 3,
  localparam int POS_W = $clog2(N*N),
  localparam int MC_W  = $clog2(N*N+1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               restart,
  input  logic               play,
  input  logic               pc,
  input  logic [POS_W-1:0]   player_position,
  input  logic [POS_W-1:0]   computer_position,
  output logic [2*N*N-1:0]   board,
  output logic [1:0]         who,
  output logic               turn,
  output logic               illegal,
  output logic [MC_W-1:0]    move_count
);

  localparam logic [POS_W:0]  C_CELLS_POS = (POS_W+1)'(N*N);
  localparam logic [MC_W-1:0] C_CELLS_MC  = MC_W'(N*N);

  typedef enum logic [1:0] {P_TURN = 2'd0, C_TURN = 2'd1, OVER = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2*N*N-1:0]  board_q, board_d;
  logic [1:0]        who_q, who_d;
  logic              turn_q, turn_d;
  logic              illegal_q, illegal_d;
  logic [MC_W-1:0]   move_count_q, move_count_d;
  logic              play_q, pc_q;

  logic              w_play_rise, w_pc_rise;
  logic              w_p_in_range, w_c_in_range;
  logic [POS_W-1:0]  w_p_idx, w_c_idx;
  logic              w_p_free, w_c_free;
  logic              w_win_p, w_win_c;
  logic              w_lp, w_lc;

  assign w_play_rise  = play & ~play_q;
  assign w_pc_rise    = pc & ~pc_q;
  assign w_p_in_range = ({1'b0, player_position} < C_CELLS_POS);
  assign w_c_in_range = ({1'b0, computer_position} < C_CELLS_POS);
  // Clamp the index so an out-of-range request never addresses past the board.
  assign w_p_idx      = w_p_in_range ? player_position : '0;
  assign w_c_idx      = w_c_in_range ? computer_position : '0;
  assign w_p_free     = (board_q[{w_p_idx, 1'b0} +: 2] == 2'b00);
  assign w_c_free     = (board_q[{w_c_idx, 1'b0} +: 2] == 2'b00);

  // Scan all 2N+2 lines of the registered board for a uniform non-zero code.
  always_comb begin
    w_win_p = 1'b0;
    w_win_c = 1'b0;
    w_lp    = 1'b0;
    w_lc    = 1'b0;
    for (int r = 0; r < N; r++) begin
      w_lp = 1'b1;
      w_lc = 1'b1;
      for (int c = 0; c < N; c++) begin
        w_lp = w_lp & (board_q[2*(r*N+c) +: 2] == 2'b01);
        w_lc = w_lc & (board_q[2*(r*N+c) +: 2] == 2'b10);
      end
      w_win_p = w_win_p | w_lp;
      w_win_c = w_win_c | w_lc;
    end
    for (int c = 0; c < N; c++) begin
      w_lp = 1'b1;
      w_lc = 1'b1;
      for (int r = 0; r < N; r++) begin
        w_lp = w_lp & (board_q[2*(r*N+c) +: 2] == 2'b01);
        w_lc = w_lc & (board_q[2*(r*N+c) +: 2] == 2'b10);
      end
      w_win_p = w_win_p | w_lp;
      w_win_c = w_win_c | w_lc;
    end
    w_lp = 1'b1;
    w_lc = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_lp = w_lp & (board_q[2*(i*N+i) +: 2] == 2'b01);
      w_lc = w_lc & (board_q[2*(i*N+i) +: 2] == 2'b10);
    end
    w_win_p = w_win_p | w_lp;
    w_win_c = w_win_c | w_lc;
    w_lp = 1'b1;
    w_lc = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_lp = w_lp & (board_q[2*(i*N+(N-1-i)) +: 2] == 2'b01);
      w_lc = w_lc & (board_q[2*(i*N+(N-1-i)) +: 2] == 2'b10);
    end
    w_win_p = w_win_p | w_lp;
    w_win_c = w_win_c | w_lc;
  end

  // Next-state: accept or reject the on-turn request, then end the game on win/draw.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    who_d        = who_q;
    turn_d       = turn_q;
    illegal_d    = 1'b0;
    move_count_d = move_count_q;
    case (state_q)
      P_TURN: begin
        if (w_play_rise) begin
          if (w_p_in_range && w_p_free) begin
            board_d[{w_p_idx, 1'b0} +: 2] = 2'b01;
            move_count_d = move_count_q + MC_W'(1);
            turn_d       = 1'b1;
            state_d      = C_TURN;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      C_TURN: begin
        if (w_pc_rise) begin
          if (w_c_in_range && w_c_free) begin
            board_d[{w_c_idx, 1'b0} +: 2] = 2'b10;
            move_count_d = move_count_q + MC_W'(1);
            turn_d       = 1'b0;
            state_d      = P_TURN;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    // A win seen on the registered board outranks a full-board draw.
    if (state_q != OVER) begin
      if (w_win_p) begin
        state_d = OVER;
        who_d   = 2'b01;
      end else if (w_win_c) begin
        state_d = OVER;
        who_d   = 2'b10;
      end else if (move_count_q == C_CELLS_MC) begin
        state_d = OVER;
        who_d   = 2'b11;
      end
    end
  end

  // State registers; restart clears synchronously, reset asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= P_TURN;
      board_q      <= '0;
      who_q        <= 2'b00;
      turn_q       <= 1'b0;
      illegal_q    <= 1'b0;
      move_count_q <= '0;
      play_q       <= 1'b0;
      pc_q         <= 1'b0;
    end else begin
      play_q <= play;
      pc_q   <= pc;
      if (restart) begin
        state_q      <= P_TURN;
        board_q      <= '0;
        who_q        <= 2'b00;
        turn_q       <= 1'b0;
        illegal_q    <= 1'b0;
        move_count_q <= '0;
      end else begin
        state_q      <= state_d;
        board_q      <= board_d;
        who_q        <= who_d;
        turn_q       <= turn_d;
        illegal_q    <= illegal_d;
        move_count_q <= move_count_d;
      end
    end
  end

  assign board      = board_q;
  assign who        = who_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign move_count = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nxn_board_game.sv
`default_nettype none
// ============================================================================
// Module      : tb_nxn_board_game
// Description : Directed self-checking bench for nxn_board_game (N=3 and N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nxn_board_game;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        restart3 = 1'b0, play3 = 1'b0, pc3 = 1'b0;
  logic [3:0]  pp3 = '0, cp3 = '0;
  logic [17:0] board3;
  logic [1:0]  who3;
  logic        turn3, ill3;
  logic [3:0]  mc3;

  logic        restart4 = 1'b0, play4 = 1'b0, pc4 = 1'b0;
  logic [3:0]  pp4 = '0, cp4 = '0;
  logic [31:0] board4;
  logic [1:0]  who4;
  logic        turn4, ill4;
  logic [4:0]  mc4;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  nxn_board_game #(.N(3)) dut3 (
    .clock(clock), .reset(reset), .restart(restart3), .play(play3), .pc(pc3),
    .player_position(pp3), .computer_position(cp3), .board(board3), .who(who3),
    .turn(turn3), .illegal(ill3), .move_count(mc3)
  );

  nxn_board_game #(.N(4)) dut4 (
    .clock(clock), .reset(reset), .restart(restart4), .play(play4), .pc(pc4),
    .player_position(pp4), .computer_position(cp4), .board(board4), .who(who4),
    .turn(turn4), .illegal(ill4), .move_count(mc4)
  );

  // One-cycle request pulse; returns at the negedge after the sampling edge.
  task automatic mv(input bit big, input bit comp, input logic [3:0] pos);
    @(negedge clock);
    if (!big) begin
      if (comp) begin cp3 = pos; pc3 = 1'b1; end
      else      begin pp3 = pos; play3 = 1'b1; end
    end else begin
      if (comp) begin cp4 = pos; pc4 = 1'b1; end
      else      begin pp4 = pos; play4 = 1'b1; end
    end
    @(negedge clock);
    play3 = 1'b0; pc3 = 1'b0; play4 = 1'b0; pc4 = 1'b0;
  endtask

  task automatic restart_both();
    @(negedge clock);
    restart3 = 1'b1; restart4 = 1'b1;
    @(negedge clock);
    restart3 = 1'b0; restart4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vecs++; if (board3 !== 18'd0) begin errs++; $display("FAIL reset_board3 got %h exp 0", board3); end
    vecs++; if (who3 !== 2'b00) begin errs++; $display("FAIL reset_who3 got %b exp 00", who3); end
    vecs++; if (turn3 !== 1'b0) begin errs++; $display("FAIL reset_turn3 got %b exp 0", turn3); end
    vecs++; if (mc3 !== 4'd0) begin errs++; $display("FAIL reset_mc3 got %0d exp 0", mc3); end
    vecs++; if (ill3 !== 1'b0) begin errs++; $display("FAIL reset_ill3 got %b exp 0", ill3); end
    vecs++; if (board4 !== 32'd0 || mc4 !== 5'd0) begin errs++; $display("FAIL reset_dut4 board %h mc %0d exp 0/0", board4, mc4); end
  endtask

  task automatic test_player_win();
    logic [17:0] exp_b;
    exp_b = '0;
    mv(0, 0, 4'd0);
    vecs++; if (board3[1:0] !== 2'b01 || turn3 !== 1'b1 || mc3 !== 4'd1) begin
      errs++; $display("FAIL pwin_first cell0 %b turn %b mc %0d exp 01/1/1", board3[1:0], turn3, mc3); end
    mv(0, 1, 4'd4);
    mv(0, 0, 4'd1);
    mv(0, 1, 4'd8);
    mv(0, 0, 4'd2);
    exp_b[1:0] = 2'b01; exp_b[3:2] = 2'b01; exp_b[5:4] = 2'b01;
    exp_b[9:8] = 2'b10; exp_b[17:16] = 2'b10;
    vecs++; if (board3 !== exp_b) begin errs++; $display("FAIL pwin_board got %h exp %h", board3, exp_b); end
    vecs++; if (who3 !== 2'b00) begin errs++; $display("FAIL pwin_who_early got %b exp 00", who3); end
    @(negedge clock);
    vecs++; if (who3 !== 2'b01) begin errs++; $display("FAIL pwin_who got %b exp 01", who3); end
    mv(0, 1, 4'd5);
    vecs++; if (mc3 !== 4'd5 || board3 !== exp_b || ill3 !== 1'b0) begin
      errs++; $display("FAIL pwin_over_pc mc %0d ill %b exp 5/0", mc3, ill3); end
  endtask

  task automatic test_illegal();
    restart_both();
    mv(0, 0, 4'd0);
    mv(0, 1, 4'd0);
    vecs++; if (ill3 !== 1'b1) begin errs++; $display("FAIL ill_occupied got %b exp 1", ill3); end
    vecs++; if (board3[1:0] !== 2'b01 || turn3 !== 1'b1 || mc3 !== 4'd1) begin
      errs++; $display("FAIL ill_keep cell0 %b turn %b mc %0d exp 01/1/1", board3[1:0], turn3, mc3); end
    @(negedge clock);
    vecs++; if (ill3 !== 1'b0) begin errs++; $display("FAIL ill_width got %b exp 0", ill3); end
    mv(0, 1, 4'd9);
    vecs++; if (ill3 !== 1'b1 || mc3 !== 4'd1) begin errs++; $display("FAIL ill_range ill %b mc %0d exp 1/1", ill3, mc3); end
    mv(0, 1, 4'd4);
    vecs++; if (board3[9:8] !== 2'b10 || turn3 !== 1'b0 || mc3 !== 4'd2 || ill3 !== 1'b0) begin
      errs++; $display("FAIL ill_accept cell4 %b turn %b mc %0d ill %b exp 10/0/2/0", board3[9:8], turn3, mc3, ill3); end
  endtask

  task automatic test_draw();
    logic [3:0] seq [9];
    seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    restart_both();
    for (int i = 0; i < 9; i++) begin
      mv(0, (i % 2) == 1, seq[i]);
      vecs++; if (ill3 !== 1'b0 || mc3 !== 4'(i + 1)) begin
        errs++; $display("FAIL draw_move%0d ill %b mc %0d exp 0/%0d", i, ill3, mc3, i + 1); end
    end
    @(negedge clock);
    vecs++; if (who3 !== 2'b11 || mc3 !== 4'd9) begin errs++; $display("FAIL draw_who got %b mc %0d exp 11/9", who3, mc3); end
    @(negedge clock);
    vecs++; if (ill3 !== 1'b0) begin errs++; $display("FAIL draw_ill got %b exp 0", ill3); end
  endtask

  task automatic test_held_simul();
    restart_both();
    @(negedge clock);
    pp3 = 4'd3; play3 = 1'b1;
    repeat (10) @(negedge clock);
    play3 = 1'b0;
    vecs++; if (mc3 !== 4'd1 || board3[7:6] !== 2'b01 || turn3 !== 1'b1) begin
      errs++; $display("FAIL held mc %0d cell3 %b turn %b exp 1/01/1", mc3, board3[7:6], turn3); end
    mv(0, 1, 4'd0);
    @(negedge clock);
    pp3 = 4'd4; cp3 = 4'd5; play3 = 1'b1; pc3 = 1'b1;
    @(negedge clock);
    play3 = 1'b0; pc3 = 1'b0;
    vecs++; if (board3[9:8] !== 2'b01 || board3[11:10] !== 2'b00 || mc3 !== 4'd3 || turn3 !== 1'b1 || ill3 !== 1'b0) begin
      errs++; $display("FAIL simul cell4 %b cell5 %b mc %0d turn %b exp 01/00/3/1", board3[9:8], board3[11:10], mc3, turn3); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    vecs++; if (board3 !== 18'd0 || mc3 !== 4'd0 || turn3 !== 1'b0) begin
      errs++; $display("FAIL async_reset board %h mc %0d turn %b exp 0/0/0", board3, mc3, turn3); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_n4_win();
    restart_both();
    mv(1, 0, 4'd0);  mv(1, 1, 4'd3);
    mv(1, 0, 4'd1);  mv(1, 1, 4'd6);
    mv(1, 0, 4'd2);  mv(1, 1, 4'd9);
    mv(1, 0, 4'd4);
    vecs++; if (who4 !== 2'b00 || ill4 !== 1'b0) begin errs++; $display("FAIL n4_midgame who %b ill %b exp 00/0", who4, ill4); end
    mv(1, 1, 4'd12);
    @(negedge clock);
    vecs++; if (who4 !== 2'b10 || mc4 !== 5'd8) begin errs++; $display("FAIL n4_cwin who %b mc %0d exp 10/8", who4, mc4); end
    vecs++; if (board4[7:6] !== 2'b10 || board4[25:24] !== 2'b10 || board4[9:8] !== 2'b01) begin
      errs++; $display("FAIL n4_board got %h", board4); end
    restart_both();
    vecs++; if (board4 !== 32'd0 || who4 !== 2'b00 || turn4 !== 1'b0 || mc4 !== 5'd0 || ill4 !== 1'b0) begin
      errs++; $display("FAIL n4_restart board %h who %b turn %b mc %0d ill %b exp all 0", board4, who4, turn4, mc4, ill4); end
    mv(1, 0, 4'd5);
    vecs++; if (board4[11:10] !== 2'b01 || mc4 !== 5'd1 || turn4 !== 1'b1) begin
      errs++; $display("FAIL n4_new_p cell5 %b mc %0d turn %b exp 01/1/1", board4[11:10], mc4, turn4); end
    mv(1, 1, 4'd15);
    vecs++; if (board4[31:30] !== 2'b10 || mc4 !== 5'd2 || turn4 !== 1'b0) begin
      errs++; $display("FAIL n4_new_c cell15 %b mc %0d turn %b exp 10/2/0", board4[31:30], mc4, turn4); end
  endtask

  initial begin
    test_reset();
    test_player_win();
    test_illegal();
    test_draw();
    test_held_simul();
    test_async_reset();
    test_n4_win();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nxn_board_game.md
# nxn_board_game

Parametrised N×N "X/O" board-game controller, the successor to the fixed 3×3 tic-tac-toe game. It alternates player and computer moves and rejects occupied or out-of-range cells with an `illegal` pulse. A win is a full row, column or either diagonal. The board is exported as a flat vector for the display/LED logic, and a win or draw freezes the game until `restart` or `reset`.

## Interface
Parameters:
- `N`, 3: board side; legal range 3..8. Cells = N*N.
- `POS_W`, $clog2(N*N): localparam giving the position width (4 for N=3).

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `restart`  in  1: synchronous clear. Same effect as reset, taking effect at the next edge.
- `play`  in  1: player move request; acts on its rising edge only.
- `pc`  in  1: computer move request; acts on its rising edge only.
- `player_position`  in  POS_W: target cell of the player, 0-based, row-major.
- `computer_position`  in  POS_W: target cell of the computer.
- `board`  out  2*N*N: cell i occupies bits [2i+1:2i]. Encoding: 00 empty, 01 player, 10 computer.
- `who`  out  2: 00 game running, 01 player won, 10 computer won, 11 draw.
- `turn`  out  1: 0 when the player is to move, 1 when the computer is to move.
- `illegal`  out  1: one-cycle pulse when a move request is rejected.
- `move_count`  out  $clog2(N*N+1): number of accepted moves.

## Operation
- Edge detect: `play_q` and `pc_q` register the previous input values every cycle, in all states. A request is valid when the input is high and its `_q` copy is low.
- FSM states:
  - P_TURN: reset state.
  - C_TURN.
  - OVER.
- P_TURN behaviour:
  - A valid `play` with `player_position` < N*N and an empty cell writes 01, increments `move_count` and moves to C_TURN.
  - A valid `play` to an occupied or out-of-range cell pulses `illegal` and stays in P_TURN.
- C_TURN: mirror of P_TURN, using `pc`, `computer_position` and value 10.
- Off-turn requests: a valid `pc` in P_TURN, or a valid `play` in C_TURN, is ignored silently. No `illegal` pulse, no state change.
- Simultaneous rising edges: only the request matching the current turn is evaluated.
- Win evaluation:
  - Done combinationally on the registered `board`.
  - A line wins when all N cells equal the same non-zero code. There are 2N+2 lines.
  - When P_TURN or C_TURN sees a winning line, the FSM moves to OVER and `who` takes that line's code.
- Draw: no winning line and `move_count` == N*N → OVER with `who`=11. A win takes priority over a draw on the final move.
- OVER: all requests are ignored and `illegal` stays 0. The FSM is left only via `restart` or `reset`.
- Reset/restart values: `board`=0, `who`=00, `turn`=0, `illegal`=0, `move_count`=0, FSM in P_TURN.
- `restart` has priority over a move request on the same edge.
- `reset` asserted mid-game clears the board immediately, without waiting for a clock edge.

## Timing
- Move latency: if a request's rising edge is sampled at edge E, then:
  - the cell, `turn` and `move_count` update at E;
  - `who` updates at E+1, one registered cycle after the completing move.
- `illegal`:
  - asserted exactly one cycle, starting at E;
  - registered, and cleared at E+1.
- Holding `play` or `pc` high for many cycles produces exactly one request. The next request needs a low cycle first.
- In the cycle between the winning write and the OVER transition, further requests of the other side are evaluated normally. The bench must avoid issuing them.
- All outputs are registered; none has a combinational path from an input.

## Test plan
- Reset: hold `reset` 10 cycles, then release → `board`=0, `who`=00, `turn`=0, `move_count`=0. Asserting `reset` asynchronously mid-game → board clears before the next edge.
- Player win, N=3: moves P0, C4, P1, C8, P2, each a 1-cycle pulse followed by a low gap.
  - `board` cells 0,1,2 = 01 and cells 4,8 = 10.
  - `who`=01 one cycle after P2.
  - A later `pc` pulse is ignored: `move_count` stays 5.
- Illegal moves, N=3:
  - P0, then C0 → `illegal` pulses for one cycle, cell 0 stays 01, `turn` stays 1.
  - `computer_position`=9 → `illegal` pulses again.
  - C4 → accepted.
- Draw, N=3: moves P0, C1, P2, C4, P3, C5, P7, C6, P8 → `who`=11, `move_count`=9, and no `illegal` pulses.
- Held and simultaneous requests:
  - `play` held high for 10 cycles at position 3 → exactly one accepted move.
  - `play` and `pc` rising on the same edge in P_TURN → only the player move is applied.
- N=4 computer win with restart:
  - The computer fills anti-diagonal cells 3, 6, 9, 12 while the player plays 0, 1, 2, 4.
  - `who`=10 after C12.
  - Pulse `restart` → all outputs return to their reset values.
  - A new game then plays normally.
